// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: turns per-stage stall requests, multi-cycle ops at
// MC_STAGE and flush requests into stall/bubble/flush controls, plus a stall watchdog.
module pipeline_ctrl #(
  parameter int NSTAGE   = 6,
  parameter int MC_STAGE = 3,
  parameter int CNTW     = 6,
  parameter int WDOG     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stall_req,
  input  logic              mc_start,
  input  logic [CNTW-1:0]   mc_cycles,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] bubble,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              mc_busy,
  output logic              stall_err
);

  localparam int WDW = $clog2(WDOG + 1);

  typedef enum logic [1:0] {IDLE, MC, FLUSH} state_t;

  state_t            state;
  logic [CNTW-1:0]   cnt;
  logic [WDW-1:0]    wd_cnt;
  logic              mc_accept;
  logic [NSTAGE-1:0] eff;
  logic              any_hi;

  // A coinciding flush wins over a new multi-cycle op.
  assign mc_accept = (state == IDLE) && mc_start && (mc_cycles != '0) && !flush_req;

  always_comb begin
    eff           = stall_req;
    eff[MC_STAGE] = stall_req[MC_STAGE] | mc_busy | mc_accept;
  end

  // stall[i] is set when any stage at or above i requests a hold; the bubble
  // goes into the first stage above the highest held one.
  always_comb begin
    stall  = '0;
    bubble = '0;
    any_hi = 1'b0;
    if (!rst && state != FLUSH) begin
      for (int i = NSTAGE - 1; i >= 0; i--) begin
        any_hi   = any_hi | eff[i];
        stall[i] = any_hi;
      end
      for (int i = 1; i < NSTAGE; i++)
        bubble[i] = stall[i-1] & ~stall[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wd_cnt    <= '0;
      flush     <= 1'b0;
      new_pc    <= '0;
      mc_busy   <= 1'b0;
      stall_err <= 1'b0;
    end else begin
      flush <= 1'b0;
      if (flush_req) begin
        state   <= FLUSH;
        flush   <= 1'b1;
        new_pc  <= flush_pc;
        mc_busy <= 1'b0;
        cnt     <= '0;
      end else begin
        case (state)
          IDLE: if (mc_accept) begin
            state   <= MC;
            cnt     <= mc_cycles;
            mc_busy <= 1'b1;
          end
          MC: begin
            cnt <= cnt - 1'b1;
            if (cnt == CNTW'(1)) begin
              state   <= IDLE;
              mc_busy <= 1'b0;
            end
          end
          FLUSH:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      if (stall[0]) begin
        if (wd_cnt != WDW'(WDOG)) wd_cnt <= wd_cnt + 1'b1;
        // Error becomes visible the same cycle the count saturates.
        if (wd_cnt >= WDW'(WDOG - 1)) stall_err <= 1'b1;
      end else begin
        wd_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized + directed bench for pipeline_ctrl against a cycle-level reference model.
module tb_pipeline_ctrl;
  localparam int NSTAGE = 6, MC_STAGE = 3, CNTW = 6, WDOG = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic [NSTAGE-1:0] stall_req;
  logic              mc_start;
  logic [CNTW-1:0]   mc_cycles;
  logic              flush_req;
  logic [31:0]       flush_pc;
  logic [NSTAGE-1:0] stall, bubble;
  logic              flush, mc_busy, stall_err;
  logic [31:0]       new_pc;

  pipeline_ctrl #(.NSTAGE(NSTAGE), .MC_STAGE(MC_STAGE), .CNTW(CNTW), .WDOG(WDOG)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .mc_start(mc_start),
    .mc_cycles(mc_cycles), .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall), .bubble(bubble), .flush(flush), .new_pc(new_pc),
    .mc_busy(mc_busy), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // reference model: remaining busy cycles, pending flush, pc, watchdog
  int        m_mc = 0;
  bit        m_flush = 0;
  bit [31:0] m_pc = 0;
  int        m_wd = 0;
  bit        m_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 0; stall_req = '0; mc_start = 0; mc_cycles = '0; flush_req = 0; flush_pc = '0;
  endtask

  // Called just after a negedge with inputs applied; checks, advances model, waits next negedge.
  task automatic cyc();
    int k;
    bit acc;
    bit [NSTAGE-1:0] e, es, eb;
    #1;
    acc = mc_start && !m_flush && m_mc == 0 && mc_cycles != 0 && !flush_req;
    e = stall_req;
    if (m_mc > 0 || acc) e[MC_STAGE] = 1'b1;
    k = -1;
    for (int i = 0; i < NSTAGE; i++) if (e[i]) k = i;
    es = '0; eb = '0;
    if (!rst && !m_flush && k >= 0) begin
      es = NSTAGE'((1 << (k + 1)) - 1);
      if (k < NSTAGE - 1) eb = NSTAGE'(1 << (k + 1));
    end
    chk("stall", 64'(stall), 64'(es));
    chk("bubble", 64'(bubble), 64'(eb));
    chk("flush", 64'(flush), 64'(m_flush));
    chk("new_pc", 64'(new_pc), 64'(m_pc));
    chk("mc_busy", 64'(mc_busy), 64'(m_mc > 0));
    chk("stall_err", 64'(stall_err), 64'(m_err));
    if (rst) begin
      m_mc = 0; m_flush = 0; m_pc = 0; m_wd = 0; m_err = 0;
    end else begin
      if (flush_req) begin
        m_flush = 1; m_pc = flush_pc; m_mc = 0;
      end else begin
        m_flush = 0;
        if (acc) m_mc = int'(mc_cycles);
        else if (m_mc > 0) m_mc--;
      end
      if (es[0]) m_wd = (m_wd + 1 > WDOG) ? WDOG : m_wd + 1;
      else m_wd = 0;
      if (m_wd == WDOG) m_err = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle_n(input int n);
    idle();
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    cyc();                                    // reset state, stall gated by rst
    stall_req = 6'b111111; cyc();             // still in reset
    idle_n(1);

    stall_req = 6'b000100; cyc();
    stall_req = 6'b100000; cyc();
    idle_n(1);

    mc_start = 1; mc_cycles = 3; cyc();
    idle_n(5);

    mc_start = 1; mc_cycles = 5; cyc();
    idle_n(2);
    flush_req = 1; flush_pc = 32'h40; cyc();
    idle_n(3);

    mc_start = 1; mc_cycles = 4; flush_req = 1; flush_pc = 32'h80; cyc();
    idle_n(3);
    mc_start = 1; mc_cycles = 0; cyc();
    idle_n(1);

    flush_req = 1; flush_pc = 32'h100; cyc();
    flush_req = 1; flush_pc = 32'h200; cyc();
    idle_n(2);

    mc_start = 1; mc_cycles = 8; cyc();
    mc_start = 1; mc_cycles = 20; cyc();      // ignored while busy
    idle_n(2);
    rst = 1; cyc();
    idle_n(3);

    stall_req = 6'b000010;
    for (int i = 0; i < WDOG + 5; i++) cyc();
    idle_n(4);
    rst = 1; cyc();
    idle_n(2);

    for (int n = 0; n < 3000; n++) begin
      idle();
      rst = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 3))
        0, 1: stall_req = '0;
        2: stall_req = NSTAGE'(1 << $urandom_range(0, NSTAGE - 1));
        default: stall_req = NSTAGE'($urandom);
      endcase
      mc_start  = ($urandom_range(0, 5) == 0);
      mc_cycles = ($urandom_range(0, 3) == 0) ? CNTW'($urandom) : CNTW'($urandom_range(0, 6));
      flush_req = ($urandom_range(0, 9) == 0);
      flush_pc  = $urandom;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
